// File: rtl/instr_fetch_mem_pkg.sv
// Shared constants and the fetch-response record for the instruction fetch memory.
package instr_fetch_mem_pkg;

   localparam int unsigned IMEM_DATA_W = 32;
   localparam int unsigned IMEM_ADDR_W = 32;

   localparam logic [IMEM_DATA_W-1:0] IMEM_NOP_WORD  = '0;
   localparam logic [IMEM_DATA_W-1:0] IMEM_HALT_WORD = '1;

   typedef struct packed {
      logic [IMEM_DATA_W-1:0] instr;
      logic [IMEM_ADDR_W-1:0] pc;
      logic                   fault;
   } fetch_rsp_t;

endpackage

// File: rtl/instr_fetch_mem_if.sv
// Request/response handshake bundle between a fetch master and instr_fetch_mem.
interface instr_fetch_mem_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_pc;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_instr;
   logic [ADDR_W-1:0] rsp_pc;
   logic              rsp_fault;

   modport master (
      output req_valid, req_pc, rsp_ready,
      input  req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault
   );

   modport slave (
      input  req_valid, req_pc, rsp_ready,
      output req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault
   );
endinterface

// File: rtl/instr_fetch_mem_ram.sv
// imem_ram: DEPTH x DATA_W storage, one synchronous write port, one registered read port.
module imem_ram #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned AW     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Array is intentionally outside the reset domain; program image survives reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: 1-cycle read, valid/ready handshake, range fault, fetch counter.
// Optional sticky halt on an all-ones fetch is enabled by defining IMEM_HALT_EN.
module instr_fetch_mem
   import instr_fetch_mem_pkg::*;
#(
   parameter int unsigned       DATA_W    = IMEM_DATA_W,
   parameter int unsigned       DEPTH     = 256,
   parameter int unsigned       ADDR_W    = IMEM_ADDR_W,
   parameter int unsigned       BYTE_ADDR = 0,
   parameter logic [DATA_W-1:0] NOP_WORD  = IMEM_NOP_WORD
) (
   input  logic                     clk,
   input  logic                     rst_n,
   instr_fetch_mem_if.slave         bus,
   input  logic                     ld_en,
   input  logic [$clog2(DEPTH)-1:0] ld_addr,
   input  logic [DATA_W-1:0]        ld_data,
   output logic                     halt,
   output logic [31:0]              fetch_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned SH = (BYTE_ADDR != 0) ? $clog2(DATA_W / 8) : 0;
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << SH) - 1);

   logic [ADDR_W-1:0] word_idx;
   logic              req_fault;
   logic              accept;
   logic [DATA_W-1:0] rd_data;
   logic              rsp_valid_q;
   logic [ADDR_W-1:0] pc_q;
   logic              fault_q;
   fetch_rsp_t        rsp;

   assign word_idx  = bus.req_pc >> SH;
   assign req_fault = (word_idx >= ADDR_W'(DEPTH)) || (|(bus.req_pc & OFF_MASK));

   assign bus.req_ready = !ld_en && !halt && (!rsp_valid_q || bus.rsp_ready);
   assign accept        = bus.req_valid && bus.req_ready;

   imem_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (ld_en),
      .wr_addr (ld_addr),
      .wr_data (ld_data),
      .rd_en   (accept && !req_fault),
      .rd_addr (word_idx[AW-1:0]),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         pc_q        <= '0;
         fault_q     <= 1'b0;
         fetch_cnt   <= '0;
      end else if (accept) begin
         rsp_valid_q <= 1'b1;
         pc_q        <= bus.req_pc;
         fault_q     <= req_fault;
         fetch_cnt   <= fetch_cnt + 32'd1;
      end else if (bus.rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   // The RAM read register holds its word until the next accepted read, so the
   // response stays stable under backpressure without a separate data register.
   always_comb begin
      rsp       = '0;
      rsp.instr = fault_q ? NOP_WORD : rd_data;
      rsp.pc    = pc_q;
      rsp.fault = fault_q;
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_instr = rsp.instr;
   assign bus.rsp_pc    = rsp.pc;
   assign bus.rsp_fault = rsp.fault;

`ifdef IMEM_HALT_EN
   logic halt_q;

   // Sentinel is detected on the registered response, so halt appears with it.
   assign halt = halt_q || (rsp_valid_q && !fault_q && (rd_data == IMEM_HALT_WORD));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) halt_q <= 1'b0;
      else        halt_q <= halt;
   end
`else
   assign halt = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: word- and byte-addressed instances share clock, reset and load port.
module tb_instr_fetch_mem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld_en;
   logic [7:0]  ld_addr;
   logic [31:0] ld_data;
   logic        halt, halt_b;
   logic [31:0] fetch_cnt, fetch_cnt_b;

   int unsigned total = 0;
   int unsigned bad   = 0;

   instr_fetch_mem_if #(.DATA_W(32), .ADDR_W(32)) bus   ();
   instr_fetch_mem_if #(.DATA_W(32), .ADDR_W(32)) bus_b ();

   instr_fetch_mem #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .BYTE_ADDR(0)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .halt      (halt),
      .fetch_cnt (fetch_cnt)
   );

   instr_fetch_mem #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .BYTE_ADDR(1)) u_dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_b.slave),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .halt      (halt_b),
      .fetch_cnt (fetch_cnt_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] a, input logic [31:0] d);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      tick();
      ld_en   = 1'b0;
   endtask

   initial begin
      rst_n         = 1'b0;
      ld_en         = 1'b0;
      ld_addr       = '0;
      ld_data       = '0;
      bus.req_valid = 1'b0;
      bus.req_pc    = '0;
      bus.rsp_ready = 1'b1;
      bus_b.req_valid = 1'b0;
      bus_b.req_pc    = '0;
      bus_b.rsp_ready = 1'b1;
      tick();
      tick();
      chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_instr", 64'(bus.rsp_instr), 64'd0);
      chk("rst_pc",    64'(bus.rsp_pc),    64'd0);
      chk("rst_fault", 64'(bus.rsp_fault), 64'd0);
      chk("rst_halt",  64'(halt),          64'd0);
      chk("rst_cnt",   64'(fetch_cnt),     64'd0);
      rst_n = 1'b1;

      for (int unsigned i = 0; i < 4; i++) load(8'(i), 32'h4420_0001 + 32'(i));
      load(8'd4,   32'h4420_0005);
      load(8'd5,   32'hFFFF_FFFF);
      load(8'd6,   32'h4420_0007);
      load(8'd255, 32'h4420_00FF);

      // Back-to-back stream, PCs 0..3
      bus.req_valid = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         bus.req_pc = 32'(i);
         #1;
         chk("stream_ready", 64'(bus.req_ready), 64'd1);
         tick();
         chk("stream_valid", 64'(bus.rsp_valid), 64'd1);
         chk("stream_pc",    64'(bus.rsp_pc),    64'(i));
         chk("stream_instr", 64'(bus.rsp_instr), 64'(32'h4420_0001 + 32'(i)));
      end
      bus.req_valid = 1'b0;
      chk("stream_cnt", 64'(fetch_cnt), 64'd4);
      tick();
      chk("stream_drain", 64'(bus.rsp_valid), 64'd0);

      // Backpressure holds PC 2 for three cycles
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'd2;
      tick();
      bus.req_pc = 32'd3;
      for (int unsigned i = 0; i < 3; i++) begin
         #1;
         chk("hold_ready", 64'(bus.req_ready), 64'd0);
         chk("hold_pc",    64'(bus.rsp_pc),    64'd2);
         chk("hold_instr", 64'(bus.rsp_instr), 64'h4420_0003);
         tick();
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("take_ready", 64'(bus.req_ready), 64'd1);
      tick();
      chk("take_pc",    64'(bus.rsp_pc),    64'd3);
      chk("take_instr", 64'(bus.rsp_instr), 64'h4420_0004);
      bus.req_valid = 1'b0;
      tick();
      chk("hold_cnt", 64'(fetch_cnt), 64'd6);

      // Range boundary: 256 faults, 255 is the last valid word
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'd256;
      tick();
      chk("oor_fault", 64'(bus.rsp_fault), 64'd1);
      chk("oor_instr", 64'(bus.rsp_instr), 64'd0);
      chk("oor_pc",    64'(bus.rsp_pc),    64'd256);
      bus.req_pc = 32'd255;
      tick();
      chk("last_fault", 64'(bus.rsp_fault), 64'd0);
      chk("last_instr", 64'(bus.rsp_instr), 64'h4420_00FF);
      bus.req_valid = 1'b0;
      tick();

      // Byte-addressed instance
      bus_b.req_valid = 1'b1;
      bus_b.req_pc    = 32'h6;
      tick();
      chk("byte_mis_fault", 64'(bus_b.rsp_fault), 64'd1);
      chk("byte_mis_instr", 64'(bus_b.rsp_instr), 64'd0);
      bus_b.req_pc = 32'h8;
      tick();
      chk("byte_ok_fault", 64'(bus_b.rsp_fault), 64'd0);
      chk("byte_ok_instr", 64'(bus_b.rsp_instr), 64'h4420_0003);
      bus_b.req_pc = 32'h400;
      tick();
      chk("byte_oor_fault", 64'(bus_b.rsp_fault), 64'd1);
      bus_b.req_valid = 1'b0;
      tick();

      // Load collides with a request to the same word
      ld_en         = 1'b1;
      ld_addr       = 8'd7;
      ld_data       = 32'h4420_ABCD;
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'd7;
      bus.rsp_ready = 1'b0;
      #1;
      chk("ld_block_ready", 64'(bus.req_ready), 64'd0);
      tick();
      chk("ld_block_valid", 64'(bus.rsp_valid), 64'd0);
      ld_en = 1'b0;
      #1;
      chk("ld_next_ready", 64'(bus.req_ready), 64'd1);
      tick();
      bus.req_valid = 1'b0;
      chk("ld_new_instr", 64'(bus.rsp_instr), 64'h4420_ABCD);
      chk("ld_new_pc",    64'(bus.rsp_pc),    64'd7);
      load(8'd7, 32'h1111_1111);
      chk("ld_held_instr", 64'(bus.rsp_instr), 64'h4420_ABCD);
      bus.rsp_ready = 1'b1;
      tick();
      chk("ld_cnt", 64'(fetch_cnt), 64'd9);

      // Halt sentinel at PC 5
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'd4;
      tick();
      chk("s4_instr", 64'(bus.rsp_instr), 64'h4420_0005);
      chk("s4_halt",  64'(halt),          64'd0);
      bus.req_pc = 32'd5;
      tick();
      chk("s5_instr", 64'(bus.rsp_instr), 64'hFFFF_FFFF);
      chk("s5_pc",    64'(bus.rsp_pc),    64'd5);
      bus.req_pc = 32'd6;
`ifdef IMEM_HALT_EN
      chk("s5_halt",  64'(halt),          64'd1);
      chk("s6_ready", 64'(bus.req_ready), 64'd0);
      for (int unsigned i = 0; i < 4; i++) tick();
      chk("s6_valid", 64'(bus.rsp_valid), 64'd0);
      chk("s6_halt",  64'(halt),          64'd1);
      chk("s6_cnt",   64'(fetch_cnt),     64'd11);
`else
      chk("s5_halt",  64'(halt),          64'd0);
      chk("s6_ready", 64'(bus.req_ready), 64'd1);
      tick();
      chk("s6_instr", 64'(bus.rsp_instr), 64'h4420_0007);
      chk("s6_halt",  64'(halt),          64'd0);
      chk("s6_cnt",   64'(fetch_cnt),     64'd12);
`endif

      // Reset mid-stream with a held response
      bus.req_pc    = 32'd1;
      bus.rsp_ready = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
      chk("mid_rst_instr", 64'(bus.rsp_instr), 64'd0);
      chk("mid_rst_pc",    64'(bus.rsp_pc),    64'd0);
      chk("mid_rst_halt",  64'(halt),          64'd0);
      chk("mid_rst_cnt",   64'(fetch_cnt),     64'd0);
      tick();
      rst_n         = 1'b1;
      bus.rsp_ready = 1'b1;
      #1;
      chk("post_rst_ready", 64'(bus.req_ready), 64'd1);
      tick();
      chk("post_rst_instr", 64'(bus.rsp_instr), 64'h4420_0002);
      chk("post_rst_cnt",   64'(fetch_cnt),     64'd1);
      bus.req_valid = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 32, instruction width in bits.
- DEPTH, 256, number of words; power of two, at least 2.
- ADDR_W, 32, request PC width.
- BYTE_ADDR, 0, 1 = PC is a byte address, word index = pc >> log2(DATA_W/8); 0 = PC is a word index.
- NOP_WORD, all-zero, word returned on a fault.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  fetch request present.
- req_ready  out  1  request accepted this cycle.
- req_pc  in  ADDR_W  fetch address.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer takes the response.
- rsp_instr  out  DATA_W  fetched word.
- rsp_pc  out  ADDR_W  PC of the response.
- rsp_fault  out  1  address was out of range.
- ld_en  in  1  program-load write strobe.
- ld_addr  in  log2(DEPTH)  load word index.
- ld_data  in  DATA_W  load data.
- halt  out  1  halt sentinel fetched (macro-dependent).
- fetch_cnt  out  32  count of accepted fetches.

Function
REQ-003 Storage SHALL be a DEPTH x DATA_W array with one synchronous write port and one synchronous read port.
REQ-004 A request SHALL be accepted when req_valid && req_ready at a rising edge.
REQ-005 req_ready SHALL equal !ld_en && !halt && (!rsp_valid || rsp_ready), evaluated combinationally.
REQ-006 Read latency SHALL be 1 cycle: after an accepted request, rsp_valid=1 at the next edge, with rsp_pc = the request PC.
REQ-007 While rsp_valid && !rsp_ready, rsp_instr, rsp_pc and rsp_fault SHALL hold stable.
REQ-008 rsp_valid SHALL clear on rsp_ready when no new request is accepted in the same cycle; a simultaneous take and accept SHALL keep rsp_valid=1 with the new data (back-to-back, 1 word per cycle).
REQ-009 Word index SHALL be computed per BYTE_ADDR. Index >= DEPTH, or with BYTE_ADDR=1 any nonzero low byte-offset bits, SHALL give rsp_instr=NOP_WORD and rsp_fault=1; there SHALL be no wrap-around.
REQ-010 ld_en=1 SHALL write ld_data to mem[ld_addr] at the edge. No request SHALL be accepted in that cycle; a held response SHALL be unaffected.
REQ-011 A word loaded at edge N and requested at edge N+1 or later SHALL return the new data.
REQ-012 fetch_cnt SHALL increment by 1 per accepted request, including faulting ones, and SHALL wrap 0xFFFFFFFF -> 0.

Reset
REQ-013 While rst_n=0, the following SHALL be 0: rsp_valid, rsp_fault, rsp_instr, rsp_pc, halt, fetch_cnt.
REQ-014 Memory contents SHALL NOT be cleared by reset; a response in flight at reset SHALL be discarded.
REQ-015 The first request SHALL be accepted at the first edge after rst_n rises.

Configuration
REQ-016 With macro IMEM_HALT_EN defined:
- A fetched non-fault word equal to all-ones SHALL set halt at the same edge that sets rsp_valid.
- halt SHALL then stay 1 until reset, forcing req_ready=0.
- The sentinel response itself SHALL still be delivered.
REQ-017 Without IMEM_HALT_EN, halt SHALL be tied 0 and all-ones SHALL be an ordinary word.

Structure
REQ-018 A shared package SHALL hold NOP_WORD, the halt sentinel constant, and the fetch-response typedef (instr, pc, fault).
REQ-019 The storage array SHALL be a sub-module imem_ram (1 write port, 1 synchronous read port); handshake, fault and halt logic SHALL live in instr_fetch_mem.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Load mem[0..3] = 0x44200001..0x44200004, then stream PCs 0..3 with rsp_ready=1 -> four responses on consecutive cycles, matching data, fetch_cnt=4.
- Hold rsp_ready=0 for 3 cycles after PC 2 -> req_ready=0, and rsp_instr/rsp_pc stay at mem[2]/2 until the take.
- DEPTH=256, BYTE_ADDR=0, PC=256 -> rsp_fault=1, rsp_instr=0. With BYTE_ADDR=1, PC=0x6 -> fault.
- Assert ld_en together with req_valid -> req_ready=0 that cycle; the request is accepted next cycle and returns the newly loaded word.
- IMEM_HALT_EN, mem[5]=0xFFFFFFFF, stream PCs 4,5,6 -> PC5 response with halt=1, and PC6 is never accepted until rst_n pulse.
- Drop rst_n mid-stream with rsp_valid=1 -> all outputs 0 immediately; memory contents are retained on re-fetch.
